// File: rtl/deser400_tp_scan_if.sv
// Signal bundle between the deser400 test-point scan sequencer (slave) and the
// block that controls it and returns the mux output (master).
interface deser400_tp_scan_if #(
   parameter int DW = 16
);
   logic          scan_en;
   logic          scan_once;
   logic [DW-1:0] dwell;
   logic [5:0]    man_sela;
   logic [5:0]    man_selb;
   logic          tpa;
   logic [5:0]    sela;
   logic [5:0]    selb;
   logic          busy;
   logic          res_valid;
   logic [5:0]    res_sel;
   logic [DW-1:0] res_count;
   logic          scan_done;

   modport master (
      output scan_en, scan_once, dwell, man_sela, man_selb, tpa,
      input  sela, selb, busy, res_valid, res_sel, res_count, scan_done
   );

   modport slave (
      input  scan_en, scan_once, dwell, man_sela, man_selb, tpa,
      output sela, selb, busy, res_valid, res_sel, res_count, scan_done
   );
endinterface

// File: rtl/deser400_tp_scan.sv
// Test-point scan sequencer for the deser400 mux: manual select pass-through, or an
// automatic sweep of all 52 points reporting the tpa high-count for each one.
module deser400_tp_scan #(
   parameter int SETTLE = 2,   // must cover the 2-stage mux pipeline
   parameter int DW     = 16
) (
   input  logic              clk,
   input  logic              reset,
   deser400_tp_scan_if.slave bus
);

   localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE - 1);
   localparam logic [5:0]      LAST_POINT  = 6'h3C;
   localparam logic [3:0]      LAST_CHAN   = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_REPORT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [SW-1:0] settle_cnt;
   logic [DW-1:0] dwell_cnt;
   logic [DW-1:0] count;
   logic [DW-1:0] dwell_load;
   logic [DW-1:0] count_final;
   logic          once_q;
   logic          start_scan;
   logic          enter_settle;
   logic          report_now;
   logic          last_point;

   assign dwell_load  = (bus.dwell == '0) ? DW'(1) : bus.dwell;
   assign count_final = count + DW'(bus.tpa);
   assign last_point  = (bus.sela == LAST_POINT);

   // Channels run 0..12; the group carry out of group 3 wraps back to point 6'h00.
   function automatic logic [5:0] next_point(input logic [5:0] p);
      logic [1:0] grp;
      logic [3:0] chan;
      grp  = p[5:4];
      chan = p[3:0];
      if (chan >= LAST_CHAN) begin
         grp  = grp + 2'd1;
         chan = 4'd0;
      end else begin
         chan = chan + 4'd1;
      end
      return {grp, chan};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      start_scan   = 1'b0;
      enter_settle = 1'b0;
      report_now   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.scan_en) begin
               state_next   = ST_SETTLE;
               start_scan   = 1'b1;
               enter_settle = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!bus.scan_en)          state_next = ST_IDLE;
            else if (settle_cnt == '0) state_next = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (!bus.scan_en) begin
               state_next = ST_IDLE;
            end else if (dwell_cnt == DW'(1)) begin
               state_next = ST_REPORT;
               report_now = 1'b1;
            end
         end
         ST_REPORT: begin
            if (!bus.scan_en || (last_point && once_q)) begin
               state_next = ST_IDLE;
            end else begin
               state_next   = ST_SETTLE;
               enter_settle = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sela      <= '0;
         bus.selb      <= '0;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_sel   <= '0;
         bus.res_count <= '0;
         bus.scan_done <= 1'b0;
         settle_cnt    <= '0;
         dwell_cnt     <= '0;
         count         <= '0;
         once_q        <= 1'b0;
      end else begin
         bus.selb      <= bus.man_selb;
         bus.busy      <= (state_next != ST_IDLE);
         bus.res_valid <= report_now;
         bus.scan_done <= report_now && last_point && once_q;

         case (state)
            ST_IDLE: begin
               if (start_scan) begin
                  bus.sela <= 6'h00;
                  once_q   <= bus.scan_once;
               end else begin
                  bus.sela <= bus.man_sela;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
               else                  count      <= '0;
            end
            ST_MEASURE: begin
               count     <= count_final;
               dwell_cnt <= dwell_cnt - DW'(1);
            end
            ST_REPORT: bus.sela <= next_point(bus.sela);
            default: ;
         endcase

         if (enter_settle) begin
            settle_cnt <= SETTLE_LOAD;
            dwell_cnt  <= dwell_load;
         end

         // Result fields load on the same edge that raises res_valid and then hold.
         if (report_now) begin
            bus.res_sel   <= bus.sela;
            bus.res_count <= count_final;
         end
      end
   end

endmodule

// File: tb/tb_deser400_tp_scan.sv
// Bench for deser400_tp_scan: a 2-stage mux model feeds tpa back, and results are
// compared against a point-list model built from the group/channel scan rules.
module tb_deser400_tp_scan;
   localparam int DW     = 16;
   localparam int SETTLE = 2;

   typedef struct {
      logic [5:0]    sel;
      logic [DW-1:0] cnt;
      logic          done;
      int            cyc;
   } res_t;

   typedef struct {
      logic [5:0] man_sela;
      logic [5:0] man_selb;
      logic [5:0] exp_sela;
      logic [5:0] exp_selb;
   } man_vec_t;

   typedef struct {
      logic [DW-1:0] dwell;
      logic [DW-1:0] exp_count;
      int            exp_period;
   } dwell_vec_t;

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   res_t        res_q[$];
   int          done_q[$];
   logic [5:0]  mux_s1;
   int          tpa_mode;   // 0: single hot point, 1: always high, 2: per-point mask
   logic [5:0]  hot_pt;
   logic [63:0] hot_mask;
   logic [5:0]  points[52];

   deser400_tp_scan_if #(.DW(DW)) bus ();

   deser400_tp_scan #(.SETTLE(SETTLE), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic mux_out(input logic [5:0] p);
      if (p[3:0] > 4'd12) return 1'b0;
      case (tpa_mode)
         0:       return (p == hot_pt);
         1:       return 1'b1;
         default: return hot_mask[p];
      endcase
   endfunction

   // Two register stages between sela and tpa, as in the real mux.
   always @(posedge clk) begin
      mux_s1  <= bus.sela;
      bus.tpa <= mux_out(mux_s1);
   end

   always @(negedge clk) begin
      res_t r;
      if (bus.res_valid) begin
         r.sel  = bus.res_sel;
         r.cnt  = bus.res_count;
         r.done = bus.scan_done;
         r.cyc  = cyc;
         res_q.push_back(r);
      end
      if (bus.scan_done) done_q.push_back(cyc);
   end

   function automatic int max1(input logic [DW-1:0] d);
      return (d == '0) ? 1 : int'(d);
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " sela"},      32'(bus.sela),      0);
      check({tag, " selb"},      32'(bus.selb),      0);
      check({tag, " busy"},      32'(bus.busy),      0);
      check({tag, " res_valid"}, 32'(bus.res_valid), 0);
      check({tag, " res_sel"},   32'(bus.res_sel),   0);
      check({tag, " res_count"}, 32'(bus.res_count), 0);
      check({tag, " scan_done"}, 32'(bus.scan_done), 0);
   endtask

   task automatic wait_results(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (res_q.size() < target && k < budget) begin
         tick();
         k++;
      end
      check({name, " result count"}, res_q.size(), target);
   endtask

   task automatic stop_scan(input string name);
      bus.scan_en = 1'b0;
      tick();
      tick();
      check({name, " stopped busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      man_vec_t   mtab[8];
      dwell_vec_t dtab[4];
      logic [5:0]    ra;
      logic [5:0]    rb;
      logic [DW-1:0] dw;
      int k;
      int base;
      int dbase;
      int per;
      int idx;
      int exp_cnt;

      for (int g = 0; g < 4; g++)
         for (int c = 0; c < 13; c++)
            points[g*13 + c] = 6'(g*16 + c);

      mtab[0] = '{6'h25, 6'h1F, 6'h25, 6'h1F};
      mtab[1] = '{6'h0D, 6'h00, 6'h0D, 6'h00};
      mtab[2] = '{6'h3F, 6'h3E, 6'h3F, 6'h3E};
      mtab[3] = '{6'h00, 6'h2F, 6'h00, 6'h2F};
      for (int i = 4; i < 8; i++) begin
         ra = 6'($urandom);
         rb = 6'($urandom);
         mtab[i] = '{ra, rb, ra, rb};
      end

      dtab[0] = '{16'd0, 16'd1, 4};
      dtab[1] = '{16'd1, 16'd1, 4};
      dtab[2] = '{16'd2, 16'd2, 5};
      dtab[3] = '{16'd5, 16'd5, 8};

      // Reset held with scan_en high: reset must win.
      reset         = 1'b1;
      bus.scan_en   = 1'b1;
      bus.scan_once = 1'b1;
      bus.dwell     = 16'd3;
      bus.man_sela  = 6'h11;
      bus.man_selb  = 6'h22;
      tpa_mode      = 1;
      hot_pt        = 6'h00;
      hot_mask      = '0;
      repeat (3) tick();
      check_zero("reset");

      // Release with scan_en still high starts a scan; then reset mid-MEASURE.
      reset = 1'b0;
      base  = res_q.size();
      k     = cyc;
      tick();
      check("start busy", 32'(bus.busy), 1);
      check("start sela", 32'(bus.sela), 0);
      wait_results(base + 1, 20, "pre-reset");
      check("pre-reset res_sel",   32'(res_q[base].sel), 0);
      check("pre-reset res_count", 32'(res_q[base].cnt), 3);
      check("pre-reset latency",   res_q[base].cyc - k, SETTLE + 3 + 1);
      repeat (3) tick();
      check("mid-measure busy", 32'(bus.busy), 1);
      reset = 1'b1;
      #1;
      check_zero("reset mid-measure");
      tick();
      bus.scan_en = 1'b0;
      reset       = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         bus.man_sela = mtab[i].man_sela;
         bus.man_selb = mtab[i].man_selb;
         tick();
         check($sformatf("manual[%0d] sela", i), 32'(bus.sela), 32'(mtab[i].exp_sela));
         check($sformatf("manual[%0d] selb", i), 32'(bus.selb), 32'(mtab[i].exp_selb));
         check($sformatf("manual[%0d] busy", i), 32'(bus.busy), 0);
      end

      // Full single scan, tpa high only at point 6'h13.
      tpa_mode      = 0;
      hot_pt        = 6'h13;
      bus.dwell     = 16'd8;
      bus.scan_once = 1'b1;
      base          = res_q.size();
      dbase         = done_q.size();
      bus.scan_en   = 1'b1;
      k             = cyc;
      wait_results(base + 52, 700, "single scan");
      bus.scan_en = 1'b0;
      for (int i = 0; i < 52; i++) begin
         idx = base + i;
         if (idx < res_q.size()) begin
            exp_cnt = (points[i] == 6'h13) ? 8 : 0;
            check($sformatf("single[%0d] res_sel", i),   32'(res_q[idx].sel),  32'(points[i]));
            check($sformatf("single[%0d] res_count", i), 32'(res_q[idx].cnt),  exp_cnt);
            check($sformatf("single[%0d] scan_done", i), 32'(res_q[idx].done), (i == 51) ? 1 : 0);
         end
      end
      check("single first latency", res_q[base].cyc - k, 11);
      check("single total cycles", res_q[base + 51].cyc - k, 52 * 11);
      check("single done pulses", done_q.size() - dbase, 1);
      check("single done with last result", done_q[dbase], res_q[base + 51].cyc);
      tick();
      check("single busy after done", 32'(bus.busy), 0);
      tick();
      check("single stays idle", 32'(bus.busy), 0);

      // Dwell table with tpa constantly high.
      tpa_mode      = 1;
      bus.scan_once = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.dwell   = dtab[i].dwell;
         base        = res_q.size();
         bus.scan_en = 1'b1;
         k           = cyc;
         wait_results(base + 3, 60, $sformatf("dwell[%0d]", i));
         stop_scan($sformatf("dwell[%0d]", i));
         for (int j = 0; j < 3; j++) begin
            check($sformatf("dwell[%0d] res_count %0d", i, j), 32'(res_q[base + j].cnt), 32'(dtab[i].exp_count));
            check($sformatf("dwell[%0d] res_sel %0d", i, j),   32'(res_q[base + j].sel), 32'(points[j]));
         end
         check($sformatf("dwell[%0d] first latency", i), res_q[base].cyc - k, dtab[i].exp_period);
         check($sformatf("dwell[%0d] period", i), res_q[base + 2].cyc - res_q[base + 1].cyc, dtab[i].exp_period);
      end

      // Largest dwell: count reaches all ones without wrapping.
      bus.dwell   = 16'hFFFF;
      base        = res_q.size();
      bus.scan_en = 1'b1;
      k           = cyc;
      wait_results(base + 1, 65600, "max dwell");
      stop_scan("max dwell");
      check("max dwell res_count", 32'(res_q[base].cnt), 32'hFFFF);
      check("max dwell latency", res_q[base].cyc - k, SETTLE + 65535 + 1);

      // Continuous scan with a random per-point tpa pattern and random dwell.
      tpa_mode      = 2;
      hot_mask      = {$urandom, $urandom};
      dw            = DW'($urandom_range(0, 5));
      bus.dwell     = dw;
      bus.scan_once = 1'b0;
      per           = SETTLE + max1(dw) + 1;
      base          = res_q.size();
      dbase         = done_q.size();
      bus.scan_en   = 1'b1;
      wait_results(base + 56, 56 * per + 20, "continuous");
      check("continuous busy", 32'(bus.busy), 1);
      stop_scan("continuous");
      for (int i = 0; i < 56; i++) begin
         idx     = base + i;
         exp_cnt = hot_mask[points[i % 52]] ? max1(dw) : 0;
         check($sformatf("cont[%0d] res_sel", i),   32'(res_q[idx].sel),  32'(points[i % 52]));
         check($sformatf("cont[%0d] res_count", i), 32'(res_q[idx].cnt),  exp_cnt);
         check($sformatf("cont[%0d] scan_done", i), 32'(res_q[idx].done), 0);
         if (i > 0) check($sformatf("cont[%0d] period", i), res_q[idx].cyc - res_q[idx - 1].cyc, per);
      end
      check("continuous no done", done_q.size() - dbase, 0);

      // Abort during MEASURE of point 6'h05.
      tpa_mode      = 1;
      bus.dwell     = 16'd10;
      bus.scan_once = 1'b1;
      base          = res_q.size();
      dbase         = done_q.size();
      bus.scan_en   = 1'b1;
      wait_results(base + 5, 80, "abort");
      check("abort last res_sel", 32'(res_q[base + 4].sel), 32'h04);
      repeat (3) tick();
      check("abort measuring busy", 32'(bus.busy), 1);
      bus.scan_en  = 1'b0;
      bus.man_sela = 6'h2A;
      tick();
      check("abort busy", 32'(bus.busy), 0);
      tick();
      check("abort sela manual", 32'(bus.sela), 32'h2A);
      repeat (30) tick();
      check("abort no result", res_q.size(), base + 5);
      check("abort res_sel held", 32'(bus.res_sel), 32'h04);
      check("abort no done", done_q.size() - dbase, 0);

      // Settle: hot point 6'h04 must not leak into neighbours at dwell 1.
      tpa_mode      = 0;
      hot_pt        = 6'h04;
      bus.dwell     = 16'd1;
      bus.scan_once = 1'b1;
      base          = res_q.size();
      bus.scan_en   = 1'b1;
      wait_results(base + 6, 40, "settle");
      stop_scan("settle");
      for (int j = 0; j < 6; j++) begin
         check($sformatf("settle[%0d] res_sel", j),   32'(res_q[base + j].sel), 32'(points[j]));
         check($sformatf("settle[%0d] res_count", j), 32'(res_q[base + j].cnt), (points[j] == 6'h04) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/deser400_tp_scan.md
# deser400_tp_scan

Test-point scan sequencer driving the `sela`/`selb` selects of the deser400 test-point multiplexer. In manual mode it registers externally supplied selects. In scan mode it steps `sela` through all 52 valid test points, 4 groups × channels 0..12. For each point it waits out the two-stage mux pipeline latency, then counts high cycles of the returned `tpa` over a programmable dwell window and reports one result per point. `selb` always stays under manual control so a second probe can be watched during a scan.

## Interface
- `SETTLE`, default 2: cycles discarded after every `sela` change; must be at least the mux pipeline depth (2).
- `DW`, default 16: width of the dwell and count fields.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `scan_en`  in  1: level; 1 = scan mode, 0 = manual mode.
- `scan_once`  in  1: 1 = stop after the last point; 0 = wrap and scan continuously. Sampled at scan start.
- `dwell`  in  DW: measurement window length in cycles; 0 is treated as 1. Sampled at entry to SETTLE for each point.
- `man_sela`  in  6: manual select A.
- `man_selb`  in  6: manual select B.
- `tpa`  in  1: mux output A, returned from the mux.
- `sela`  out  6: select A to the mux; `[5:4]` group, `[3:0]` channel.
- `selb`  out  6: select B to the mux.
- `busy`  out  1: high while not IDLE.
- `res_valid`  out  1: one-cycle result strobe.
- `res_sel`  out  6: test point the result belongs to.
- `res_count`  out  DW: number of cycles with `tpa` = 1 during the window.
- `scan_done`  out  1: one-cycle pulse after the last point when `scan_once` = 1.

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT.
- **IDLE**
  - `sela` <= `man_sela` every cycle; `busy` = 0.
  - On `scan_en` = 1: `sela` <= 6'h00; latch `scan_once`; go to SETTLE.
- **SETTLE**
  - Load the dwell counter with max(`dwell`, 1).
  - Stay `SETTLE` cycles, ignoring `tpa`; then go to MEASURE with the count cleared.
- **MEASURE**
  - Each cycle: count += `tpa`; dwell counter decrements.
  - On the cycle the dwell counter reaches 1 (including that cycle's `tpa`), go to REPORT.
- **REPORT**, one cycle
  - `res_valid` = 1; `res_sel` = current `sela`; `res_count` = final count.
  - Advance `sela`: channel < 12 → channel+1; channel = 12 → {group+1, 4'd0}.
  - After 6'h3C (group 3, channel 12), wrap to 6'h00.
  - On the wrap with latched `scan_once` = 1: pulse `scan_done`, go to IDLE.
  - Otherwise go to SETTLE.
- Channel codes 13..15 are never generated in scan mode. In manual mode they pass through unchanged; the mux outputs 0 for them.
- `selb` <= `man_selb` every cycle in all states.
- `scan_en` falling in any non-IDLE state: go to IDLE next cycle, abandon the current point, no `res_valid`, no `scan_done`.
- Count never overflows: count ≤ dwell ≤ 2^DW − 1.

## Timing
- Reset: `sela` = 0, `selb` = 0, `busy` = 0, `res_valid` = 0, `res_sel` = 0, `res_count` = 0, `scan_done` = 0, state IDLE, counters 0.
- All outputs are registered. `res_sel` and `res_count` hold their values until the next `res_valid`.
- Manual mode: `sela`/`selb` follow `man_sela`/`man_selb` with 1-cycle latency.
- Scan start: `scan_en` high at edge N → `sela` = 0 and `busy` = 1 after edge N.
- Per point: SETTLE (`SETTLE`) + MEASURE (max(`dwell`,1)) + REPORT (1) cycles.
  - Full 52-point scan, `SETTLE` = 2, `dwell` = 10: 52 × 13 = 676 cycles.
- `tpa` sampled in MEASURE reflects the current `sela`, because the mux adds 2 register stages and `SETTLE` ≥ 2.
- `scan_done` coincides with the final `res_valid`. `busy` drops the cycle after.
- `scan_en` and `reset` asserted together: reset wins. `scan_en` is re-evaluated in IDLE after reset release.

## Test plan
- **Reset and manual mode**
  - Reset mid-MEASURE → all outputs 0 immediately.
  - Then `man_sela` = 6'h25, `man_selb` = 6'h1F → `sela` = 6'h25, `selb` = 6'h1F one cycle later; `busy` = 0.
- **Single scan with mux model**
  - Bench mux model (2-cycle latency); `tpa` tied high only at test point 6'h13; `dwell` = 8, `scan_once` = 1.
  - 52 `res_valid` pulses with `res_sel` sequence 00..0C, 10..1C, 20..2C, 30..3C.
  - `res_count` = 8 only at 6'h13, 0 elsewhere.
  - `scan_done` with the `res_sel` = 6'h3C result; total 52 × 11 = 572 cycles.
- **Dwell boundaries**
  - `dwell` = 0 with `tpa` = 1 → `res_count` = 1, 4 cycles per point.
  - `dwell` = 16'hFFFF with `tpa` = 1 → `res_count` = 16'hFFFF, no wrap.
- **Continuous scan**
  - `scan_once` = 0 → after `res_sel` = 6'h3C the next `res_sel` = 6'h00; no `scan_done`; `busy` stays 1.
- **Abort**
  - Drop `scan_en` during MEASURE of point 6'h05 → no `res_valid` for 6'h05.
  - IDLE next cycle; `sela` = `man_sela` one cycle later.
- **Settle correctness**
  - `tpa` model high only on point 6'h04; point 6'h03 measured with `dwell` = 1 → `res_count` = 0 for 6'h03, 1 for 6'h04, showing no leakage from the stale pipeline.
